// File: rtl/countdown_if.sv
// countdown_if: control and display bus of the MM:SS countdown engine.
//   load, start_stop      control pulses into the engine
//   preset_3..preset_0    BCD preset value (MM:SS), digit 3 = minutes tens
//   digit_3..digit_0      registered BCD count out to the display stage
//   enable_3..enable_0    per-digit display enables
//   running, done         status flags
// Modports: master = controller/bench side, slave = countdown_core.
interface countdown_if;
    logic       load;
    logic       start_stop;
    logic [3:0] preset_3;
    logic [3:0] preset_2;
    logic [3:0] preset_1;
    logic [3:0] preset_0;
    logic [3:0] digit_3;
    logic [3:0] digit_2;
    logic [3:0] digit_1;
    logic [3:0] digit_0;
    logic       enable_3;
    logic       enable_2;
    logic       enable_1;
    logic       enable_0;
    logic       running;
    logic       done;

    modport master (
        output load, start_stop, preset_3, preset_2, preset_1, preset_0,
        input  digit_3, digit_2, digit_1, digit_0,
        input  enable_3, enable_2, enable_1, enable_0, running, done
    );

    modport slave (
        input  load, start_stop, preset_3, preset_2, preset_1, preset_0,
        output digit_3, digit_2, digit_1, digit_0,
        output enable_3, enable_2, enable_1, enable_0, running, done
    );
endinterface

// File: rtl/countdown_core.sv
// countdown_core: MM:SS countdown engine feeding a four-digit multiplexed display.
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   countdown_if.slave: load/start_stop/preset_3..0 in,
//         digit_3..0, enable_3..0, running, done out (all registered)
// Parameter CLK_DIV: clk cycles per one-second step (>=2, even with blink).
// Optional macro COUNTDOWN_BLINK_EN: all digit enables blink 0.5 s on/0.5 s off in DONE;
// when undefined the display shows a steady 00:00 in DONE.
module countdown_core #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    countdown_if.slave  bus
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
`ifdef COUNTDOWN_BLINK_EN
    localparam logic [PW-1:0] HALF = PW'(CLK_DIV / 2 - 1);
`endif

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [3:0]    d3, d2, d1, d0;
    logic          en3, en2, en1, en0;
    logic          running, done;
`ifdef COUNTDOWN_BLINK_EN
    logic          blink_on;
`endif

    logic [3:0] l3, l2, l1, l0;
    logic [3:0] n3, n2, n1, n0;
    logic       b0, b1, b2;
    logic       tick, zero, next_zero;

    // Clamped preset and the count one second lower (BCD borrow chain)
    always_comb begin
        l3 = (bus.preset_3 > 4'd5) ? 4'd5 : bus.preset_3;
        l2 = (bus.preset_2 > 4'd9) ? 4'd9 : bus.preset_2;
        l1 = (bus.preset_1 > 4'd5) ? 4'd5 : bus.preset_1;
        l0 = (bus.preset_0 > 4'd9) ? 4'd9 : bus.preset_0;

        b0 = (d0 == 4'd0);
        n0 = b0 ? 4'd9 : d0 - 4'd1;
        b1 = b0 && (d1 == 4'd0);
        n1 = b0 ? ((d1 == 4'd0) ? 4'd5 : d1 - 4'd1) : d1;
        b2 = b1 && (d2 == 4'd0);
        n2 = b1 ? ((d2 == 4'd0) ? 4'd9 : d2 - 4'd1) : d2;
        // 00:00 never steps, so guard the top digit against wrapping anyway
        n3 = (b2 && (d3 != 4'd0)) ? d3 - 4'd1 : d3;

        zero      = ({d3, d2, d1, d0} == 16'h0000);
        next_zero = ({n3, n2, n1, n0} == 16'h0000);
        tick      = (presc == LAST);
    end

    // State machine, prescaler, count and registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            presc   <= '0;
            d3      <= 4'd0;
            d2      <= 4'd0;
            d1      <= 4'd0;
            d0      <= 4'd0;
            en3     <= 1'b0;
            en2     <= 1'b1;
            en1     <= 1'b1;
            en0     <= 1'b1;
            running <= 1'b0;
            done    <= 1'b0;
`ifdef COUNTDOWN_BLINK_EN
            blink_on <= 1'b1;
`endif
        end else if (bus.load) begin
            state   <= IDLE;
            presc   <= '0;
            d3      <= l3;
            d2      <= l2;
            d1      <= l1;
            d0      <= l0;
            en3     <= (l3 != 4'd0);
            en2     <= 1'b1;
            en1     <= 1'b1;
            en0     <= 1'b1;
            running <= 1'b0;
            done    <= 1'b0;
`ifdef COUNTDOWN_BLINK_EN
            blink_on <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_stop && !zero) begin
                        state   <= RUN;
                        presc   <= '0;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // A pause request freezes the prescaler on that very edge
                    if (bus.start_stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (tick) begin
                        presc <= '0;
                        d3    <= n3;
                        d2    <= n2;
                        d1    <= n1;
                        d0    <= n0;
                        if (next_zero) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                            en3     <= 1'b1;
                            en2     <= 1'b1;
                            en1     <= 1'b1;
                            en0     <= 1'b1;
`ifdef COUNTDOWN_BLINK_EN
                            blink_on <= 1'b1;
`endif
                        end else begin
                            en3 <= (n3 != 4'd0);
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                PAUSE: begin
                    if (bus.start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    presc <= tick ? '0 : presc + PW'(1);
`ifdef COUNTDOWN_BLINK_EN
                    if ((presc == HALF) || tick) begin
                        blink_on <= ~blink_on;
                        en3      <= ~blink_on;
                        en2      <= ~blink_on;
                        en1      <= ~blink_on;
                        en0      <= ~blink_on;
                    end
`endif
                    // Acknowledge: back to IDLE showing 00:00 with the leading blank
                    if (bus.start_stop) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        en3   <= 1'b0;
                        en2   <= 1'b1;
                        en1   <= 1'b1;
                        en0   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.digit_3  = d3;
    assign bus.digit_2  = d2;
    assign bus.digit_1  = d1;
    assign bus.digit_0  = d0;
    assign bus.enable_3 = en3;
    assign bus.enable_2 = en2;
    assign bus.enable_1 = en1;
    assign bus.enable_0 = en0;
    assign bus.running  = running;
    assign bus.done     = done;

endmodule

// File: tb/tb_countdown_core.sv
// tb_countdown_core: scoreboard bench for countdown_core with CLK_DIV=4.
// A reference model keeps the count as whole seconds; each driven cycle pushes the
// expected outputs, and a monitor compares them after every rising edge.
// Honours COUNTDOWN_BLINK_EN the same way as the design.
module tb_countdown_core;

    localparam int unsigned CLK_DIV = 4;
    localparam int HALF    = int'(CLK_DIV) / 2;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst;

    countdown_if bus ();

    countdown_core #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [21:0] exp_q[$];
    logic [21:0] mon_e;
    logic [21:0] mon_g;

    int m_secs  = 0;
    int m_mode  = M_IDLE;
    int m_presc = 0;

    function automatic int clampd(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Expected outputs derived from the model's seconds count and mode
    function automatic logic [21:0] model_out();
        int mins, secs;
        logic [3:0] e3, e2, e1, e0, en;
        mins = m_secs / 60;
        secs = m_secs % 60;
        e3 = 4'(mins / 10);
        e2 = 4'(mins % 10);
        e1 = 4'(secs / 10);
        e0 = 4'(secs % 10);
        if (m_mode == M_DONE) begin
`ifdef COUNTDOWN_BLINK_EN
            en = (m_presc < HALF) ? 4'hF : 4'h0;
`else
            en = 4'hF;
`endif
        end else begin
            en = {(e3 != 4'd0), 3'b111};
        end
        return {e3, e2, e1, e0, en, (m_mode == M_RUN), (m_mode == M_DONE)};
    endfunction

    function automatic void model_step(input bit r, input bit l, input bit ss,
                                       input int p3, input int p2, input int p1, input int p0);
        if (r) begin
            m_secs = 0; m_mode = M_IDLE; m_presc = 0;
        end else if (l) begin
            m_secs  = (clampd(p3, 5) * 10 + clampd(p2, 9)) * 60
                    + clampd(p1, 5) * 10 + clampd(p0, 9);
            m_presc = 0;
            m_mode  = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (ss && m_secs > 0) begin
                    m_mode = M_RUN; m_presc = 0;
                end
                M_RUN: if (ss) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_presc++;
                    if (m_presc == int'(CLK_DIV)) begin
                        m_presc = 0;
                        m_secs--;
                        if (m_secs == 0) m_mode = M_DONE;
                    end
                end
                M_PAUSE: if (ss) m_mode = M_RUN;
                M_DONE: begin
                    m_presc = (m_presc + 1) % int'(CLK_DIV);
                    if (ss) m_mode = M_IDLE;
                end
                default: ;
            endcase
        end
    endfunction

    // One clock of stimulus: drive at the falling edge, record the expected result
    task automatic cyc(input bit r, input bit l, input bit ss,
                       input logic [3:0] p3, input logic [3:0] p2,
                       input logic [3:0] p1, input logic [3:0] p0);
        @(negedge clk);
        rst            = r;
        bus.load       = l;
        bus.start_stop = ss;
        bus.preset_3   = p3;
        bus.preset_2   = p2;
        bus.preset_1   = p1;
        bus.preset_0   = p0;
        model_step(r, l, ss, int'(p3), int'(p2), int'(p1), int'(p0));
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic press();
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic do_load(input logic [3:0] p3, input logic [3:0] p2,
                           input logic [3:0] p1, input logic [3:0] p0);
        cyc(1'b0, 1'b1, 1'b0, p3, p2, p1, p0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] digits();
        return {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0};
    endfunction

    function automatic logic [3:0] enables();
        return {bus.enable_3, bus.enable_2, bus.enable_1, bus.enable_0};
    endfunction

    // Scoreboard monitor: one expected record per rising edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_g = {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0,
                     bus.enable_3, bus.enable_2, bus.enable_1, bus.enable_0,
                     bus.running, bus.done};
            total++;
            if (mon_g !== mon_e) begin
                bad++;
                $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, mon_g, mon_e);
            end
        end
    end

    initial begin
        logic [3:0] ep;
        bit r, l, ss;
        logic [3:0] p3, p2, p1, p0;

        rst            = 1'b1;
        bus.load       = 1'b0;
        bus.start_stop = 1'b0;
        bus.preset_3   = 4'd0;
        bus.preset_2   = 4'd0;
        bus.preset_1   = 4'd0;
        bus.preset_0   = 4'd0;

        // Reset values
        after_edge();
        chk("rst_digits", 32'(digits()), 32'h0000);
        chk("rst_enables", 32'(enables()), 32'h7);
        chk("rst_running", 32'(bus.running), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(2);

        // 10:00 counts down across the minute boundary
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        press();
        idle(4);
        after_edge();
        chk("step_10_00", 32'(digits()), 32'h0959);
        idle(8);
        after_edge();
        chk("step_09_57", 32'(digits()), 32'h0957);

        // Reset in the middle of a run
        do_load(4'd0, 4'd3, 4'd1, 4'd7);
        press();
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        after_edge();
        chk("midrst_digits", 32'(digits()), 32'h0000);
        chk("midrst_en3", 32'(bus.enable_3), 32'd0);
        chk("midrst_running", 32'(bus.running), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        idle(1);

        // Out-of-range preset clamps per digit
        do_load(4'd7, 4'hC, 4'd6, 4'hF);
        after_edge();
        chk("clamp_digits", 32'(digits()), 32'h5959);
        chk("clamp_en3", 32'(bus.enable_3), 32'd1);

        // 00:02 runs to DONE; enables in DONE; acknowledge; restart with 00:00
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        press();
        idle(7);
        after_edge();
        chk("pre_done_digits", 32'(digits()), 32'h0001);
        chk("pre_done_flags", 32'({bus.running, bus.done}), 32'h2);
        idle(1);
        after_edge();
        chk("done_digits", 32'(digits()), 32'h0000);
        chk("done_flags", 32'({bus.running, bus.done}), 32'h1);
        chk("done_en_0", 32'(enables()), 32'hF);
        for (int k = 1; k < 8; k++) begin
            idle(1);
            after_edge();
`ifdef COUNTDOWN_BLINK_EN
            ep = ((k % 4) < 2) ? 4'hF : 4'h0;
`else
            ep = 4'hF;
`endif
            chk($sformatf("done_en_%0d", k), 32'(enables()), 32'(ep));
        end
        press();
        after_edge();
        chk("ack_flags", 32'({bus.running, bus.done}), 32'h0);
        chk("ack_enables", 32'(enables()), 32'h7);
        press();
        after_edge();
        chk("zero_start_flags", 32'({bus.running, bus.done}), 32'h0);

        // Load wins over start_stop in the same cycle while in DONE
        do_load(4'd0, 4'd0, 4'd0, 4'd1);
        press();
        idle(4);
        after_edge();
        chk("done2_flags", 32'({bus.running, bus.done}), 32'h1);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd9);
        after_edge();
        chk("load_ss_flags", 32'({bus.running, bus.done}), 32'h0);
        chk("load_ss_digits", 32'(digits()), 32'h0009);
        chk("load_ss_enables", 32'(enables()), 32'h7);

        // Pause part way into a second, then resume from the held prescaler
        do_load(4'd0, 4'd0, 4'd0, 4'd5);
        press();
        idle(2);
        press();
        idle(20);
        after_edge();
        chk("paused_digits", 32'(digits()), 32'h0005);
        chk("paused_running", 32'(bus.running), 32'd0);
        press();
        idle(1);
        after_edge();
        chk("resume_hold", 32'(digits()), 32'h0005);
        idle(1);
        after_edge();
        chk("resume_step", 32'(digits()), 32'h0004);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 399) == 0);
            l  = ($urandom_range(0, 59) == 0);
            ss = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) != 0) begin
                p3 = 4'd0;
                p2 = 4'd0;
                p1 = 4'($urandom_range(0, 1));
                p0 = 4'($urandom_range(0, 15));
            end else begin
                p3 = 4'($urandom_range(0, 15));
                p2 = 4'($urandom_range(0, 15));
                p1 = 4'($urandom_range(0, 15));
                p0 = 4'($urandom_range(0, 15));
            end
            cyc(r, l, ss, p3, p2, p1, p0);
        end
        idle(2);
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
